// File: rtl/tile_pkg.sv
// Shared definitions for the tile-map write scheduler: requester count, word
// widths, FSM encoding and the round-robin slot helper.
package tile_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned TILE_W  = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned PTR_W   = 2;

    typedef enum logic [0:0] {
        TILE_IDLE  = 1'b0,
        TILE_CLEAR = 1'b1
    } tile_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TILE_W-1:0] data;
    } tile_wr_t;

    // k-th requester visited when the search starts just after ptr
    function automatic logic [PTR_W-1:0] rr_slot(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned      k);
        return PTR_W'((32'(ptr) + 32'd1 + k) % NUM_REQ);
    endfunction

endpackage

// File: rtl/tile_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant among unmasked requests,
// searching from the slot after the pointer.
module tile_rr_arb
    import tile_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o_c
);

    logic [NUM_REQ-1:0] elig_c;
    logic               found_c;
    logic [PTR_W-1:0]   slot_c;

    assign elig_c = req_i & ~mask_i;

    always_comb begin
        gnt_o_c = '0;
        found_c = 1'b0;
        slot_c  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            slot_c = rr_slot(ptr_i, k);
            if (!found_c && elig_c[slot_c]) begin
                gnt_o_c[slot_c] = 1'b1;
                found_c         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_wr_sched.sv
// Tile-map write scheduler: round-robin arbitration of three writers onto one
// tile-RAM write port, plus an optional full-map clear sweep (TILE_WR_SCHED_CLEAR_EN).
module tile_wr_sched
    import tile_pkg::*;
#(
    parameter int unsigned MAP_DEPTH = 1200,
    parameter logic [15:0] CLR_TILE  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [15:0] req_addr0,
    input  logic [15:0] req_addr1,
    input  logic [15:0] req_addr2,
    input  logic [15:0] req_data0,
    input  logic [15:0] req_data1,
    input  logic [15:0] req_data2,
    output logic [2:0]  gnt,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        we,
    output logic [15:0] addr,
    output logic [15:0] dina
);

    localparam int unsigned      CNT_W   = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    tile_wr_t           wr_c [NUM_REQ];
    logic [NUM_REQ-1:0] arb_gnt_c;
    logic               clr_fire_c;
    logic [CNT_W-1:0]   clr_cnt_c;

    logic               we_q, we_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [TILE_W-1:0]  dina_q, dina_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    assign wr_c[0] = '{addr: req_addr0, data: req_data0};
    assign wr_c[1] = '{addr: req_addr1, data: req_data1};
    assign wr_c[2] = '{addr: req_addr2, data: req_data2};

    // Last cycle's grant is masked so a requester cannot be written twice
    tile_rr_arb u_arb (
        .req_i   (req),
        .mask_i  (gnt_q),
        .ptr_i   (ptr_q),
        .gnt_o_c (arb_gnt_c)
    );

`ifdef TILE_WR_SCHED_CLEAR_EN
    tile_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TILE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q holds the next sweep address; address 0 is issued on the start edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            TILE_IDLE: begin
                if (clr_start && (MAP_DEPTH > 1)) begin
                    state_d = TILE_CLEAR;
                    cnt_d   = CNT_W'(1);
                end
            end
            TILE_CLEAR: begin
                if (cnt_q == CNT_W'(MAP_DEPTH - 1)) begin
                    state_d = TILE_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = TILE_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_fire_c = (state_q == TILE_CLEAR) || clr_start;
    assign clr_cnt_c  = (state_q == TILE_CLEAR) ? cnt_q : '0;
`else
    logic unused_clr_start;

    assign unused_clr_start = clr_start;
    assign clr_fire_c       = 1'b0;
    assign clr_cnt_c        = '0;
`endif

    // Clear sweep owns the port; otherwise issue the arbiter winner or idle
    always_comb begin
        we_d   = 1'b0;
        gnt_d  = '0;
        addr_d = addr_q;
        dina_d = dina_q;
        busy_d = 1'b0;
        ptr_d  = ptr_q;
        if (clr_fire_c) begin
            we_d   = 1'b1;
            addr_d = ADDR_W'(clr_cnt_c);
            dina_d = CLR_TILE;
            busy_d = 1'b1;
        end else if (|arb_gnt_c) begin
            we_d  = 1'b1;
            gnt_d = arb_gnt_c;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (arb_gnt_c[i]) begin
                    addr_d = wr_c[i].addr;
                    dina_d = wr_c[i].data;
                    ptr_d  = PTR_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            gnt_q  <= '0;
            addr_q <= '0;
            dina_q <= '0;
            busy_q <= 1'b0;
            ptr_q  <= PTR_RST;
        end else begin
            we_q   <= we_d;
            gnt_q  <= gnt_d;
            addr_q <= addr_d;
            dina_q <= dina_d;
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
        end
    end

    assign we       = we_q;
    assign gnt      = gnt_q;
    assign addr     = addr_q;
    assign dina     = dina_q;
    assign clr_busy = busy_q;

endmodule

// File: tb/tb_tile_wr_sched.sv
// Self-checking bench for tile_wr_sched: directed arbitration/clear scenarios
// and a randomized request stream against a behavioural reference model.
module tb_tile_wr_sched;

    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] CLR   = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [15:0] req_addr [3];
    logic [15:0] req_data [3];
    logic        clr_start;
    logic [2:0]  gnt;
    logic        clr_busy;
    logic        we;
    logic [15:0] addr;
    logic [15:0] dina;

    // {we, gnt, addr, dina, clr_busy}
    logic [36:0] obs;
    logic [36:0] exp_v;

    int checks   = 0;
    int failures = 0;

    int          m_last;
    int          m_prev;
    logic [15:0] m_addr;
    logic [15:0] m_dina;

    tile_wr_sched #(
        .MAP_DEPTH (DEPTH),
        .CLR_TILE  (CLR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr0 (req_addr[0]),
        .req_addr1 (req_addr[1]),
        .req_addr2 (req_addr[2]),
        .req_data0 (req_data[0]),
        .req_data1 (req_data[1]),
        .req_data2 (req_data[2]),
        .gnt       (gnt),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .we        (we),
        .addr      (addr),
        .dina      (dina)
    );

    always #5 clk = ~clk;

    assign obs = {we, gnt, addr, dina, clr_busy};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_last = 2;
        m_prev = -1;
        m_addr = 16'h0000;
        m_dina = 16'h0000;
    endtask

    // Expected outputs after the next edge, from the currently driven requests
    task automatic model_predict(output logic [36:0] e);
        int w;
        w = -1;
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (w < 0 && req[c] && c != m_prev) w = c;
        end
        if (w >= 0) begin
            m_addr = req_addr[w];
            m_dina = req_data[w];
            m_last = w;
            m_prev = w;
            e = {1'b1, 3'(3'b001 << w), m_addr, m_dina, 1'b0};
        end else begin
            m_prev = -1;
            e = {1'b0, 3'b000, m_addr, m_dina, 1'b0};
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = 3'b000;
        clr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        clr_start = 1'b0;
        req       = 3'b111;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = 16'h0040 + 16'(i);
            req_data[i] = 16'h7700 + 16'(i);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 37'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", c, obs, 37'd0);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_v = {1'b1, 3'b001, 16'h0040, 16'h7700, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_first_grant got=%h want=%h", obs, exp_v);
        end
        req = 3'b000;
    endtask

    task automatic test_round_robin();
        int seq [4];
        seq = '{0, 1, 2, 0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = 16'd100 + 16'(i);
            req_data[i] = 16'hD000 + 16'(i);
        end
        req = 3'b111;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            exp_v = {1'b1, 3'(3'b001 << seq[c]), 16'd100 + 16'(seq[c]),
                     16'hD000 + 16'(seq[c]), 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL round_robin cyc=%0d got=%h want=%h", c, obs, exp_v);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_single_requester();
        apply_reset();
        req_addr[1] = 16'd17;
        req_data[1] = 16'h0085;
        req         = 3'b010;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c % 2 == 0) exp_v = {1'b1, 3'b010, 16'd17, 16'h0085, 1'b0};
            else            exp_v = {1'b0, 3'b000, 16'd17, 16'h0085, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL single_req cyc=%0d got=%h want=%h", c, obs, exp_v);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            model_predict(exp_v);
            @(posedge clk);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d req=%b got=%h want=%h", c, req, obs, exp_v);
            end
            for (int i = 0; i < 3; i++) begin
                if (m_prev == i) begin
                    if ($urandom_range(1, 0) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        req_addr[i] = 16'($urandom);
                        req_data[i] = 16'($urandom);
                    end
                end else if (!req[i] && $urandom_range(99, 0) < 40) begin
                    req[i]      = 1'b1;
                    req_addr[i] = 16'($urandom);
                    req_data[i] = 16'($urandom);
                end
            end
        end
        req = 3'b000;
    endtask

`ifdef TILE_WR_SCHED_CLEAR_EN
    task automatic test_clear();
        int busy_cnt;
        busy_cnt = 0;
        apply_reset();
        clr_start = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(posedge clk);
            #1;
            clr_start = 1'b0;
            busy_cnt += int'(clr_busy);
            exp_v = {1'b1, 3'b000, 16'(k), CLR, 1'b1};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL clear_sweep k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (k == 3) clr_start = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            busy_cnt += int'(clr_busy);
            exp_v = {1'b0, 3'b000, 16'(DEPTH - 1), CLR, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL clear_done cyc=%0d got=%h want=%h", c, obs, exp_v);
            end
        end
        checks++;
        if (busy_cnt != int'(DEPTH)) begin
            failures++;
            $display("FAIL clear_busy_len got=%0d want=%0d", busy_cnt, DEPTH);
        end
    endtask

    task automatic test_clear_vs_req();
        apply_reset();
        req_addr[2] = 16'h0222;
        req_data[2] = 16'hBEEF;
        req         = 3'b100;
        clr_start   = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(posedge clk);
            #1;
            clr_start = 1'b0;
            exp_v = {1'b1, 3'b000, 16'(k), CLR, 1'b1};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL clear_prio k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end
        @(posedge clk);
        #1;
        exp_v = {1'b1, 3'b100, 16'h0222, 16'hBEEF, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL clear_then_req got=%h want=%h", obs, exp_v);
        end
        req = 3'b000;
    endtask

    task automatic test_clear_reset();
        apply_reset();
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_v = {1'b1, 3'b000, 16'd3, CLR, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL clear_at3 got=%h want=%h", obs, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 37'd0) begin
            failures++;
            $display("FAIL clear_abort got=%h want=%h", obs, 37'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 37'd0) begin
                failures++;
                $display("FAIL clear_no_resume cyc=%0d got=%h want=%h", c, obs, 37'd0);
            end
        end
    endtask
`else
    task automatic test_clear_disabled();
        apply_reset();
        clr_start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            clr_start = 1'b0;
            checks++;
            if (obs !== 37'd0) begin
                failures++;
                $display("FAIL clear_disabled cyc=%0d got=%h want=%h", c, obs, 37'd0);
            end
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req       = 3'b000;
        clr_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = 16'h0000;
            req_data[i] = 16'h0000;
        end
        model_reset();
        test_reset();
        test_round_robin();
        test_single_requester();
        test_random();
`ifdef TILE_WR_SCHED_CLEAR_EN
        test_clear();
        test_clear_vs_req();
        test_clear_reset();
`else
        test_clear_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_wr_sched.md
TILE_WR_SCHED -- requirements
Module: tile_wr_sched

Interface
REQ-001 SHALL have parameter MAP_DEPTH, default 1200, number of tile-map words (40x30 tiles).
REQ-002 SHALL have parameter CLR_TILE, default 16'h0000, tile word written by the clear sweep.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  3  per-requester write request, held until granted.
REQ-006 SHALL have port req_addr0/1/2  input  16 each  per-requester tile-map address.
REQ-007 SHALL have port req_data0/1/2  input  16 each  per-requester tile word.
REQ-008 SHALL have port gnt  output  3  one-cycle grant pulse, coincident with the issued write.
REQ-009 SHALL have port clr_start  input  1  one-cycle pulse, starts a full-map clear.
REQ-010 SHALL have port clr_busy  output  1  high while the clear sweep runs.
REQ-011 SHALL have port we  output  1  tile-RAM write enable.
REQ-012 SHALL have port addr  output  16  tile-RAM write address.
REQ-013 SHALL have port dina  output  16  tile-RAM write data.

Function
REQ-014 SHALL register we/addr/dina/gnt: a request sampled at edge N appears on the outputs after edge N (1-cycle latency).
REQ-015 SHALL issue at most one write per cycle; gnt SHALL be one-hot or zero.
REQ-016 SHALL arbitrate round-robin: the search starts at (last granted + 1) mod 3; the pointer reset value is 2, so req[0] wins first.
REQ-017 SHALL mask requester i from arbitration in any cycle where gnt[i]=1, preventing a duplicate write while the requester drops or updates req.
REQ-018 SHALL drive we=0, gnt=0 and hold addr/dina at their previous values when no request is eligible.
REQ-019 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_start; CLEAR->IDLE after the write to address MAP_DEPTH-1.
REQ-020 SHALL, in CLEAR, write CLR_TILE to addresses 0..MAP_DEPTH-1, one per cycle with we=1, and grant no requester.
REQ-021 SHALL ignore clr_start while in CLEAR (no restart).
REQ-022 SHALL, when clr_start and a req coincide in IDLE, give the clear priority, leaving requests pending until CLEAR exits.
REQ-023 SHALL assert clr_busy from the cycle after clr_start through the cycle carrying the final clear write.
REQ-024 SHALL size the clear counter to $clog2(MAP_DEPTH) bits, zero-extended onto addr.

Reset
REQ-025 SHALL, while rst_n=0, force we=0, gnt=0, addr=0, dina=0, clr_busy=0, FSM=IDLE, clear counter=0 and RR pointer=2.
REQ-026 SHALL abort a clear sweep if rst_n falls mid-sweep; there is no resume.

Configuration
REQ-027 SHALL, with TILE_WR_SCHED_CLEAR_EN defined, include the CLEAR state and counter as specified.
REQ-028 SHALL, without TILE_WR_SCHED_CLEAR_EN, ignore clr_start, tie clr_busy=0, omit the counter and act as a pure arbiter.

Structure
REQ-029 SHALL place the requester count (3), the tile word width (16) and the FSM state encoding in shared package tile_pkg.
REQ-030 SHALL implement the round-robin arbiter as sub-module tile_rr_arb (req, mask, pointer in; one-hot grant out).

Verification
REQ-031 SHALL cover: req=3'b111 held, all addrs distinct -> grants in order 0,1,2,0 with matching addr/dina, one write per cycle.
REQ-032 SHALL cover: only req[1] held with addr 17, data 16'h0085 -> writes on alternate cycles, gnt=3'b010 each time.
REQ-033 SHALL cover: MAP_DEPTH=8, clr_start -> 8 consecutive writes to addr 0..7 with dina=CLR_TILE; clr_busy high exactly 8 cycles.
REQ-034 SHALL cover: clr_start coincident with req[2] -> clear runs first; req[2] granted the cycle after the last clear write.
REQ-035 SHALL cover: rst_n low at clear address 3 -> outputs zero immediately, clr_busy=0; after release, no further writes without a new clr_start.
REQ-036 SHALL cover: build without TILE_WR_SCHED_CLEAR_EN, pulse clr_start -> we stays 0 and clr_busy stays 0.
